// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S defaults, sample-pair type and word-select polarity
package i2s_pkg;

  localparam int I2S_BITSIZE   = 24;
  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_BCLK_DIV  = 4;

  // Word-select level for the left slot; the right slot uses the inverse.
  localparam logic LRCLK_LEFT = 1'b0;

  typedef struct packed {
    logic [I2S_BITSIZE-1:0] left;
    logic [I2S_BITSIZE-1:0] right;
  } i2s_pair_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - BCLK divider with registered bclk and a fall strobe
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic fall
);

  localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             rise;

  // Strobes flag the clk edge at which bclk changes level.
  always_comb begin
    rise   = (div_q == DIV_W'(BCLK_DIV / 2 - 1));
    fall   = (div_q == DIV_W'(BCLK_DIV - 1));
    div_d  = fall ? '0 : div_q + 1'b1;
    bclk_d = bclk_q;
    if (rise) bclk_d = 1'b1;
    if (fall) bclk_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk = bclk_q;

endmodule

// File: rtl/i2s_master_tx.sv
// rtl/i2s_master_tx.sv - I2S master transmitter: bit counter, frame buffer and serializer
module i2s_master_tx
  import i2s_pkg::*;
#(
  parameter int BITSIZE   = I2S_BITSIZE,
  parameter int BCLK_DIV  = I2S_BCLK_DIV,
  parameter int SLOT_BITS = I2S_SLOT_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BITSIZE-1:0] left_in,
  input  logic [BITSIZE-1:0] right_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               bclk,
  output logic               lrclk,
  output logic               sdata,
  output logic               frame_start,
  output logic               underrun
);

  localparam int CNT_W = $clog2(2 * SLOT_BITS);
  localparam int IDX_W = (BITSIZE > 1) ? $clog2(BITSIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] BIT_LEN  = CNT_W'(BITSIZE);

  if ((BCLK_DIV < 2) || (BCLK_DIV % 2 != 0)) begin : g_bad_div
    $error("i2s_master_tx: BCLK_DIV must be even and >= 2");
  end
  if (SLOT_BITS < BITSIZE + 1) begin : g_bad_slot
    $error("i2s_master_tx: SLOT_BITS must be >= BITSIZE+1");
  end

  logic                   fall;
  logic [CNT_W-1:0]       bitcnt_q, bitcnt_d, cnt_nxt, pos;
  logic [2*BITSIZE-1:0]   holding_q, holding_d, active_q, active_d;
  logic                   hold_valid_q, hold_valid_d;
  logic                   lrclk_q, lrclk_d, sdata_q, sdata_d;
  logic                   frame_start_q, frame_start_d, underrun_q, underrun_d;
  logic                   in_ready_q, in_ready_d;
  logic                   wrap, right_slot;
  logic [BITSIZE-1:0]     ch_word;
  logic [IDX_W-1:0]       idx;

  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .bclk  (bclk),
    .fall  (fall)
  );

  always_comb begin
    cnt_nxt    = (bitcnt_q == CNT_LAST) ? '0 : bitcnt_q + 1'b1;
    wrap       = fall && (bitcnt_q == CNT_LAST);
    right_slot = (cnt_nxt >= SLOT_LEN);
    pos        = right_slot ? cnt_nxt - SLOT_LEN : cnt_nxt;
    ch_word    = right_slot ? active_q[BITSIZE-1:0] : active_q[2*BITSIZE-1:BITSIZE];
    idx        = IDX_W'(BIT_LEN - pos);

    bitcnt_d      = bitcnt_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    active_d      = active_q;
    holding_d     = holding_q;
    hold_valid_d  = hold_valid_q;

    // Slot bit 0 is the one-BCLK I2S delay; bits past BITSIZE pad with zero.
    if (fall) begin
      bitcnt_d = cnt_nxt;
      lrclk_d  = right_slot ? ~LRCLK_LEFT : LRCLK_LEFT;
      sdata_d  = ((pos != '0) && (pos <= BIT_LEN)) ? ch_word[idx] : 1'b0;
    end

    // Without a fresh pair the old holding value is replayed.
    if (wrap) begin
      active_d      = holding_q;
      hold_valid_d  = 1'b0;
      underrun_d    = !hold_valid_q;
      frame_start_d = 1'b1;
    end

    // A transfer on the wrap cycle lands after the copy above, so it waits a frame.
    if (in_valid && in_ready_q) begin
      holding_d    = {left_in, right_in};
      hold_valid_d = 1'b1;
    end

    in_ready_d = !hold_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt_q      <= '0;
      holding_q     <= '0;
      active_q      <= '0;
      hold_valid_q  <= 1'b0;
      lrclk_q       <= LRCLK_LEFT;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      in_ready_q    <= 1'b1;
    end else begin
      bitcnt_q      <= bitcnt_d;
      holding_q     <= holding_d;
      active_q      <= active_d;
      hold_valid_q  <= hold_valid_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      in_ready_q    <= in_ready_d;
    end
  end

  assign lrclk       = lrclk_q;
  assign sdata       = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign in_ready    = in_ready_q;

endmodule

// File: tb/tb_i2s_master_tx.sv
// tb/tb_i2s_master_tx.sv - self-checking bench for i2s_master_tx with defaults (24/4/32)
module tb_i2s_master_tx;

  localparam int FRAME = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] left_in, right_in;
  logic        in_valid;
  logic        in_ready, bclk, lrclk, sdata, frame_start, underrun;

  always #5 clk = ~clk;

  i2s_master_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .left_in     (left_in),
    .right_in    (right_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference state: n = clk edges since reset release.
  int          n;
  logic [47:0] m_hold, m_active;
  logic        m_hv, m_fs, m_ur;

  typedef struct packed {
    int          cyc;
    logic        vld;
    logic [23:0] l;
    logic [23:0] r;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int c, logic vl, logic [23:0] l, logic [23:0] r, logic [5:0] e);
    vec_t v;
    v.cyc = c; v.vld = vl; v.l = l; v.r = r; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
    else n_pass++;
  endtask

  task automatic model_reset();
    n = 0; m_hold = '0; m_active = '0; m_hv = 1'b0; m_fs = 1'b0; m_ur = 1'b0;
  endtask

  task automatic model_edge();
    logic xfer;
    n++;
    xfer = in_valid && !m_hv;
    m_fs = (n % FRAME == 0);
    m_ur = m_fs && !m_hv;
    if (m_fs) begin
      m_active = m_hold;
      m_hv     = 1'b0;
    end
    if (xfer) begin
      m_hold = {left_in, right_in};
      m_hv   = 1'b1;
    end
  endtask

  task automatic check_model();
    int          bc, p;
    logic [23:0] ch;
    logic        e_sd;
    bc   = (n / 4) % 64;
    p    = bc % 32;
    ch   = (bc < 32) ? m_active[47:24] : m_active[23:0];
    e_sd = (p >= 1 && p <= 24) ? ch[24-p] : 1'b0;
    chk("m_bclk",  bclk,        (n % 4) >= 2);
    chk("m_lrclk", lrclk,       bc >= 32);
    chk("m_sdata", sdata,       e_sd);
    chk("m_fs",    frame_start, m_fs);
    chk("m_ur",    underrun,    m_ur);
    chk("m_rdy",   in_ready,    !m_hv);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic run_until(input int target);
    while (n < target) step();
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    in_valid = 1'b1; left_in = l; right_in = r;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int   ur_cnt, rdy_cnt, fs_cnt;
    logic took;

    rst_n = 1'b0; in_valid = 1'b0; left_in = '0; right_in = '0;
    model_reset();
    repeat (10) @(negedge clk);
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_ur", underrun, 0);
    chk("rst_rdy", in_ready, 1);
    rst_n = 1'b1;

    // {bclk, lrclk, sdata, frame_start, underrun, in_ready} after edge cyc
    vecs.push_back(mk(1,   0, 24'h0,      24'h0,      6'b000001));
    vecs.push_back(mk(2,   0, 24'h0,      24'h0,      6'b100001));
    vecs.push_back(mk(4,   0, 24'h0,      24'h0,      6'b000001));
    vecs.push_back(mk(10,  1, 24'hA5A5A5, 24'h123456, 6'b100000));
    vecs.push_back(mk(11,  0, 24'h0,      24'h0,      6'b100000));
    vecs.push_back(mk(128, 0, 24'h0,      24'h0,      6'b010000));
    vecs.push_back(mk(130, 0, 24'h0,      24'h0,      6'b110000));
    vecs.push_back(mk(256, 0, 24'h0,      24'h0,      6'b000101));
    vecs.push_back(mk(257, 0, 24'h0,      24'h0,      6'b000001));
    vecs.push_back(mk(260, 0, 24'h0,      24'h0,      6'b001001));
    vecs.push_back(mk(264, 0, 24'h0,      24'h0,      6'b000001));
    vecs.push_back(mk(268, 0, 24'h0,      24'h0,      6'b001001));
    vecs.push_back(mk(352, 0, 24'h0,      24'h0,      6'b001001));
    vecs.push_back(mk(356, 0, 24'h0,      24'h0,      6'b000001));
    vecs.push_back(mk(384, 0, 24'h0,      24'h0,      6'b010001));
    vecs.push_back(mk(400, 0, 24'h0,      24'h0,      6'b011001));
    vecs.push_back(mk(476, 0, 24'h0,      24'h0,      6'b011001));
    vecs.push_back(mk(480, 0, 24'h0,      24'h0,      6'b010001));
    vecs.push_back(mk(512, 0, 24'h0,      24'h0,      6'b000111));

    foreach (vecs[i]) begin
      run_until(vecs[i].cyc - 1);
      in_valid = vecs[i].vld; left_in = vecs[i].l; right_in = vecs[i].r;
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_bclk", vecs[i].cyc),  bclk,        vecs[i].exp[5]);
      chk($sformatf("v%0d_lrclk", vecs[i].cyc), lrclk,       vecs[i].exp[4]);
      chk($sformatf("v%0d_sdata", vecs[i].cyc), sdata,       vecs[i].exp[3]);
      chk($sformatf("v%0d_fs", vecs[i].cyc),    frame_start, vecs[i].exp[2]);
      chk($sformatf("v%0d_ur", vecs[i].cyc),    underrun,    vecs[i].exp[1]);
      chk($sformatf("v%0d_rdy", vecs[i].cyc),   in_ready,    vecs[i].exp[0]);
    end

    // Underrun: one negative pair, then starve for three frames.
    run_until(519);
    push(24'h800000, 24'h7FFFFF);
    ur_cnt = 0;
    while (n < 1536) begin
      step();
      if (underrun) ur_cnt++;
      if (n == 1028) chk("neg_msb_repeat", sdata, 1);
      if (n == 1032) chk("neg_bit22_repeat", sdata, 0);
    end
    chk("underrun_count", ur_cnt, 3);

    // Collision: transfer lands exactly on the wrap edge.
    run_until(1791);
    push(24'hC0FFEE, 24'h0ABCDE);
    chk("coll_rdy", in_ready, 0);
    chk("coll_fs", frame_start, 1);
    chk("coll_ur", underrun, 1);
    run_until(1800);
    chk("coll_old_pair", sdata, 0);
    run_until(2056);
    chk("coll_new_pair", sdata, 1);

    // Back-pressure: valid held high, data changes only after each transfer.
    run_until(2048);
    in_valid = 1'b1; left_in = 24'($urandom); right_in = 24'($urandom);
    rdy_cnt = 0; fs_cnt = 0;
    while (n < 3072) begin
      took = !m_hv;
      step();
      if (took) begin left_in = 24'($urandom); right_in = 24'($urandom); end
      if (in_ready) rdy_cnt++;
      if (frame_start) fs_cnt++;
    end
    chk("bp_rdy_cycles", rdy_cnt, 4);
    chk("bp_frames", fs_cnt, 4);
    in_valid = 1'b0;

    // Random sparse traffic against the model.
    while (n < 4608) begin
      if (!in_valid && $urandom_range(0, 199) == 0) begin
        in_valid = 1'b1; left_in = 24'($urandom); right_in = 24'($urandom);
      end
      took = in_valid && !m_hv;
      step();
      if (took) in_valid = 1'b0;
    end
    in_valid = 1'b0;

    // Reset mid-frame at bitcnt 17 while bclk and sdata are high.
    run_until(4864);
    push(24'hFFFFFF, 24'hFFFFFF);
    run_until(5120 + 70);
    chk("pre_rst_bclk", bclk, 1);
    chk("pre_rst_sdata", sdata, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bclk", bclk, 0);
    chk("arst_lrclk", lrclk, 0);
    chk("arst_sdata", sdata, 0);
    chk("arst_fs", frame_start, 0);
    chk("arst_ur", underrun, 0);
    chk("arst_rdy", in_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    ur_cnt = 0;
    while (n < 512) begin
      step();
      if (underrun) ur_cnt++;
    end
    chk("post_rst_underruns", ur_cnt, 2);
    run_until(520);
    push(24'h3C3C3C, 24'hC3C3C3);
    run_until(772);
    chk("post_rst_data", sdata, 0);
    chk("post_rst_no_ur", underrun, 0);
    run_until(784);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2s_master_tx.md
Name: i2s_master_tx

Overview:
- I2S transmitter for the case where the FPGA is clock master and the codec is slave.
- From one system clock it generates BCLK and LRCLK, and serializes 24-bit stereo samples onto SDATA in standard I2S format (MSB one BCLK after the LRCLK edge).
- Samples arrive on a valid/ready handshake and are double-buffered per frame.
- Sits between the sample path (NCO/DSP) and the codec DAC pins.

Parameters:
- BITSIZE, 24: sample width per channel.
- BCLK_DIV, 4: clk cycles per BCLK period. Must be even and >=2.
- SLOT_BITS, 32: BCLK periods per channel slot. Must be >= BITSIZE+1.

Ports:
- clk  in  1  system clock (MCLK domain, 12.288 MHz nominal).
- rst_n  in  1  reset, asynchronous, active-low.
- left_in  in  BITSIZE  left sample, two's complement.
- right_in  in  BITSIZE  right sample.
- in_valid  in  1  sample pair valid.
- in_ready  out  1  holding register empty; transfer occurs when in_valid & in_ready at a clk edge.
- bclk  out  1  bit clock.
- lrclk  out  1  word select; 0 = left slot, 1 = right slot.
- sdata  out  1  serial data.
- frame_start  out  1  one-clk pulse at the start of each frame.
- underrun  out  1  one-clk pulse when a frame starts with no new sample.

Behaviour:
- Reset values (rst_n low, asynchronous): bclk=0, lrclk=0, sdata=0, frame_start=0, underrun=0, in_ready=1; divider=0, bitcnt=0, holding=0, hold_valid=0, active frame=0.
- All outputs are registered.
- Divider d counts 0..BCLK_DIV-1 and wraps.
- Edge d: BCLK_DIV/2-1 -> BCLK_DIV/2 ("rise"): bclk <= 1.
- Edge d: BCLK_DIV-1 -> 0 ("fall"):
  - bclk <= 0;
  - bitcnt advances modulo 2*SLOT_BITS;
  - lrclk and sdata update.
- Data changes only at fall; the codec samples on the BCLK rising edge.
- lrclk = (bitcnt >= SLOT_BITS), evaluated on the new bitcnt.
- Slot position p = bitcnt mod SLOT_BITS; channel = left if bitcnt < SLOT_BITS, else right.
- sdata = active[BITSIZE-p] for 1 <= p <= BITSIZE; sdata = 0 for p = 0 and for p > BITSIZE.
- Frame period = 2*SLOT_BITS*BCLK_DIV clk cycles; 256 with defaults, giving 48 kHz at 12.288 MHz.
- Frame wrap is the fall edge where bitcnt goes 2*SLOT_BITS-1 -> 0:
  - if hold_valid: active <= holding, hold_valid <= 0;
  - else: active <= holding (repeat of the previous pair, or zeros after reset), underrun <= 1 for one cycle;
  - frame_start <= 1 for one cycle, coincident with the bclk/lrclk update.
- Handshake:
  - in_ready = !hold_valid;
  - on transfer: holding <= {left_in, right_in}, hold_valid <= 1.
- Simultaneous transfer and frame wrap in the same cycle: active takes the OLD holding; holding takes the new data; hold_valid ends at 1. The new pair is used at the next frame.
- in_valid while in_ready = 0: ignored. The source must hold its data.
- The first frame after reset outputs zeros: bitcnt starts at 0 with active=0.
- Reset mid-frame: immediate return to reset values. Buffered data is discarded. No partial frame resumes.
- Illegal parameter values (odd BCLK_DIV, BCLK_DIV < 2, SLOT_BITS < BITSIZE+1) are rejected at elaboration.

Decomposition:
- Shared package i2s_pkg holds:
  - defaults I2S_BITSIZE=24, I2S_SLOT_BITS=32;
  - typedef for a stereo sample pair {left, right} of BITSIZE bits;
  - LRCLK_LEFT=0 constant, shared with i2s_rx and i2s_tx.
- Sub-module i2s_bclk_gen contains the divider, registered bclk, and rise/fall strobes. The serializer, bit counter and buffer stay in i2s_master_tx.

Test Plan:
- Reset: hold rst_n=0 for 10 clks -> bclk=lrclk=sdata=0, in_ready=1. Release -> first bclk rise at clk 2 and fall at clk 4 (BCLK_DIV=4); lrclk rises at clk 128 and falls at 256.
- Serialization: push left=0xA5A5A5, right=0x123456 before the first wrap -> in the second frame:
  - sdata = 0 at bitcnt 0;
  - bitcnt 1..24 carry 1010_0101... MSB-first;
  - zeros at 25..31;
  - right bits 0x123456 at bitcnt 33..56;
  - frame_start pulses exactly every 256 clks.
- Underrun: push one pair, then hold in_valid=0 -> the next frame repeats the same bits and underrun pulses once per frame. A negative sample 0x800000 repeats sign-correctly.
- Collision: assert in_valid with the holding register empty on the exact wrap cycle -> the active frame uses the previous pair; the new pair appears one frame later; in_ready=0 afterwards.
- Back-pressure: in_valid held high continuously -> exactly one transfer per frame; in_ready high for exactly one cycle after each wrap.
- Reset mid-frame: assert rst_n=0 at bitcnt=17 -> outputs go to 0 asynchronously with no clk edge. After release, a zero frame is followed by underrun until new data arrives.
